// File: rtl/bigmul_unit_param_pkg.sv
// Shared constants and width helpers for the
// multi-precision multiplier.
package bigmul_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CLEAR = 2'd1;
   localparam logic [1:0] ST_MAC   = 2'd2;
   localparam logic [1:0] ST_FIN   = 2'd3;

   localparam logic WR_SEL_A = 1'b0;
   localparam logic WR_SEL_B = 1'b1;

   // ceil(log2(v)), never below 1 so that
   // single-limb builds keep legal widths
   function automatic int clog2_min1(
      input int v
   );
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return (r < 1) ? 1 : r;
   endfunction

   function automatic int len_w(input int m);
      return clog2_min1(m + 1);
   endfunction

   function automatic int addr_w(input int m);
      return clog2_min1(m);
   endfunction

   function automatic int raddr_w(input int m);
      return clog2_min1(2 * m);
   endfunction

endpackage

// File: rtl/bigmul_unit_param_if.sv
// Load/start/read port bundle between the core
// and the multiplier.
interface bigmul_if
   import bigmul_pkg::*;
#(
   parameter int LIMB_W    = 64,
   parameter int MAX_LIMBS = 64
) ();

   localparam int LEN_W = len_w(MAX_LIMBS);
   localparam int AW    = addr_w(MAX_LIMBS);
   localparam int RAW   = raddr_w(MAX_LIMBS);

   logic              start;
   logic [LEN_W-1:0]  len;
   logic              sq;
   logic              wr_en;
   logic              wr_sel;
   logic [AW-1:0]     wr_addr;
   logic [LIMB_W-1:0] wr_data;
   logic [RAW-1:0]    rd_addr;
   logic [LIMB_W-1:0] rd_data;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output start, len, sq,
      output wr_en, wr_sel, wr_addr, wr_data,
      output rd_addr,
      input  rd_data, busy, done, err
   );

   modport slave (
      input  start, len, sq,
      input  wr_en, wr_sel, wr_addr, wr_data,
      input  rd_addr,
      output rd_data, busy, done, err
   );

endinterface

// File: rtl/bigmul_unit_param_limb_mac.sv
// One limb product plus two limb addends;
// the result always fits in 2*W bits.
module limb_mac #(
   parameter int W = 64
) (
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   input  logic [W-1:0]   c0,
   input  logic [W-1:0]   c1,
   output logic [2*W-1:0] p
);

   logic [2*W-1:0] ax;
   logic [2*W-1:0] bx;
   logic [2*W-1:0] c0x;
   logic [2*W-1:0] c1x;

   assign ax  = {{W{1'b0}}, a};
   assign bx  = {{W{1'b0}}, b};
   assign c0x = {{W{1'b0}}, c0};
   assign c1x = {{W{1'b0}}, c1};
   assign p   = ax * bx + c0x + c1x;

endmodule

// File: rtl/bigmul_unit_param.sv
// Schoolbook multi-precision multiplier with
// runtime length, square mode and length checks.
module bigmul_unit_param
   import bigmul_pkg::*;
#(
   parameter int LIMB_W    = 64,
   parameter int MAX_LIMBS = 64
) (
   input  logic     clk,
   input  logic     rst,
   bigmul_if.slave  bus
);

   localparam int LEN_W = len_w(MAX_LIMBS);
   localparam int AW    = addr_w(MAX_LIMBS);
   localparam int RAW   = raddr_w(MAX_LIMBS);
   localparam int CW    = LEN_W + 1;
   localparam int RN    = 2 * MAX_LIMBS;

   localparam logic [CW-1:0] MAX_C =
      CW'(MAX_LIMBS);
   localparam logic [CW-1:0] ONE_C =
      CW'(1);

   logic [LIMB_W-1:0] a_mem [MAX_LIMBS];
   logic [LIMB_W-1:0] b_mem [MAX_LIMBS];
   logic [LIMB_W-1:0] r_mem [RN];

   logic [1:0]        state_q;
   logic              busy_q;
   logic              done_q;
   logic              err_q;
   logic              sq_q;
   logic [CW-1:0]     len_q;
   logic [CW-1:0]     i_q;
   logic [CW-1:0]     j_q;
   logic [CW-1:0]     k_q;
   logic [LIMB_W-1:0] carry_q;
   logic [LIMB_W-1:0] rd_q;

   logic [CW-1:0]       len_ext;
   logic                len_ok;
   logic                idle;
   logic                accept;
   logic                reject;
   logic                wr_ok;
   logic [CW-1:0]       r_idx;
   logic [CW-1:0]       len2;
   logic                last_j;
   logic                last_i;
   logic                last_k;
   logic [LIMB_W-1:0]   a_op;
   logic [LIMB_W-1:0]   b_op;
   logic [LIMB_W-1:0]   r_cur;
   logic [2*LIMB_W-1:0] mac_p;
   logic                r_we;
   logic [RAW-1:0]      r_waddr;
   logic [LIMB_W-1:0]   r_wdata;

   assign len_ext = {1'b0, bus.len};
   assign len_ok  = (len_ext != '0) &&
                    (len_ext <= MAX_C);
   assign idle    = (state_q == ST_IDLE);
   assign accept  = idle && bus.start && len_ok;
   assign reject  = idle && bus.start && !len_ok;
   assign wr_ok   = idle && bus.wr_en && !rst;

   assign r_idx  = i_q + j_q;
   assign len2   = len_q << 1;
   assign last_j = (j_q == len_q);
   assign last_i = (i_q == len_q - ONE_C);
   assign last_k = (k_q == len2 - ONE_C);

   assign a_op  = a_mem[i_q[AW-1:0]];
   assign b_op  = sq_q ? a_mem[j_q[AW-1:0]]
                       : b_mem[j_q[AW-1:0]];
   assign r_cur = r_mem[r_idx[RAW-1:0]];

   limb_mac #(
      .W (LIMB_W)
   ) u_mac (
      .a  (a_op),
      .b  (b_op),
      .c0 (r_cur),
      .c1 (carry_q),
      .p  (mac_p)
   );

   // result-store write port: zero fill, then
   // row partial sums and the row carry-out
   always_comb begin
      r_we    = 1'b0;
      r_waddr = r_idx[RAW-1:0];
      r_wdata = '0;
      case (state_q)
         ST_CLEAR: begin
            r_we    = 1'b1;
            r_waddr = k_q[RAW-1:0];
         end
         ST_MAC: begin
            r_we    = 1'b1;
            r_wdata = last_j ? carry_q
                             : mac_p[LIMB_W-1:0];
         end
         default: r_we = 1'b0;
      endcase
      if (rst) r_we = 1'b0;
   end

   // control FSM, counters and status pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         sq_q    <= 1'b0;
         len_q   <= '0;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         carry_q <= '0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  len_q   <= len_ext;
                  sq_q    <= bus.sq;
                  k_q     <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_CLEAR;
               end else if (reject) begin
                  err_q <= 1'b1;
               end
            end
            ST_CLEAR: begin
               if (last_k) begin
                  i_q     <= '0;
                  j_q     <= '0;
                  carry_q <= '0;
                  state_q <= ST_MAC;
               end else begin
                  k_q <= k_q + ONE_C;
               end
            end
            ST_MAC: begin
               if (last_j) begin
                  carry_q <= '0;
                  j_q     <= '0;
                  if (last_i) state_q <= ST_FIN;
                  else        i_q <= i_q + ONE_C;
               end else begin
                  carry_q <=
                     mac_p[2*LIMB_W-1:LIMB_W];
                  j_q <= j_q + ONE_C;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // limb stores; contents survive reset
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         if (bus.wr_sel == WR_SEL_A)
            a_mem[bus.wr_addr] <= bus.wr_data;
         else
            b_mem[bus.wr_addr] <= bus.wr_data;
      end
      if (r_we) r_mem[r_waddr] <= r_wdata;
   end

   // registered result read, live while busy
   always_ff @(posedge clk) begin
      if (rst)
         rd_q <= '0;
      else if (int'(bus.rd_addr) < RN)
         rd_q <= r_mem[bus.rd_addr];
      else
         rd_q <= '0;
   end

   assign bus.rd_data = rd_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.err     = err_q;

endmodule

// File: tb/tb_bigmul_unit_param.sv
// Directed-vector bench for the parametrised
// multi-precision multiplier.
module tb_bigmul_unit_param;
   import bigmul_pkg::*;

   localparam int W = 64;
   localparam int M = 64;
   localparam logic [W-1:0] ONES = '1;
   localparam logic [W-1:0] HALF =
      64'h7FFF_FFFF_FFFF_FFFF;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bigmul_if #(
      .LIMB_W    (W),
      .MAX_LIMBS (M)
   ) bus ();

   bigmul_unit_param #(
      .LIMB_W    (W),
      .MAX_LIMBS (M)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int vectors = 0;
   int miscompares = 0;
   logic [W-1:0] ta [M];
   logic [W-1:0] tbv [M];
   logic [W-1:0] exp_r [2*M];

   task automatic chk(
      input string tag,
      input logic [W-1:0] obs,
      input logic [W-1:0] exp
   );
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
      end
   endtask

   task automatic wr(
      input logic sel,
      input int addr,
      input logic [W-1:0] d
   );
      @(negedge clk);
      bus.wr_en   = 1'b1;
      bus.wr_sel  = sel;
      bus.wr_addr = 6'(addr);
      bus.wr_data = d;
      @(posedge clk);
      #1 bus.wr_en = 1'b0;
   endtask

   task automatic rd(
      input int addr,
      output logic [W-1:0] d
   );
      @(negedge clk);
      bus.rd_addr = 7'(addr);
      @(posedge clk);
      #1 d = bus.rd_data;
   endtask

   task automatic start_job(
      input int l,
      input logic s
   );
      @(negedge clk);
      bus.start = 1'b1;
      bus.len   = 7'(l);
      bus.sq    = s;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   task automatic wait_done(
      input int limit,
      output int n
   );
      n = 0;
      while (!bus.done && n < limit) begin
         @(posedge clk);
         #1 n++;
      end
      if (!bus.done) n = -1;
   endtask

   task automatic run(
      input int l,
      input logic s,
      input int exp_n,
      input string tag
   );
      int n;
      start_job(l, s);
      chk({tag, " busy"}, W'(bus.busy), 1);
      wait_done(6000, n);
      chk({tag, " cycles"}, W'(n), W'(exp_n));
      chk({tag, " busy@done"}, W'(bus.busy), 0);
   endtask

   initial begin
      logic [W-1:0] d;
      logic [191:0] acc;
      logic [127:0] p;
      int n;
      int seen;

      bus.start   = 1'b0;
      bus.len     = '0;
      bus.sq      = 1'b0;
      bus.wr_en   = 1'b0;
      bus.wr_sel  = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.rd_addr = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst busy", W'(bus.busy), 0);
      chk("rst done", W'(bus.done), 0);
      chk("rst err", W'(bus.err), 0);
      chk("rst rd_data", bus.rd_data, 0);
      @(negedge clk);
      rst = 1'b0;

      // single max limb
      wr(WR_SEL_A, 0, ONES);
      wr(WR_SEL_B, 0, ONES);
      run(1, 1'b0, 5, "t1");
      rd(0, d);
      chk("t1 R0", d, 64'h1);
      rd(1, d);
      chk("t1 R1", d, 64'hFFFF_FFFF_FFFF_FFFE);

      // full size, column-wise reference
      for (int i = 0; i < M; i++) begin
         ta[i]  = HALF;
         tbv[i] = HALF;
         wr(WR_SEL_A, i, HALF);
         wr(WR_SEL_B, i, HALF);
      end
      acc = '0;
      for (int k = 0; k < 2*M; k++) begin
         for (int i = 0; i < M; i++) begin
            if (k - i >= 0 && k - i < M) begin
               p = 128'(ta[i]) * 128'(tbv[k-i]);
               acc = acc + 192'(p);
            end
         end
         exp_r[k] = acc[W-1:0];
         acc = acc >> W;
      end
      run(64, 1'b0, 4289, "t3");
      rd(0, d);
      chk("t3 R0", d, 64'h1);
      for (int k = 0; k < 2*M; k++) begin
         rd(k, d);
         chk($sformatf("t3 R%0d", k), d,
             exp_r[k]);
      end

      // two limbs; R4 keeps the previous run
      wr(WR_SEL_A, 0, 64'd1);
      wr(WR_SEL_A, 1, 64'd1);
      wr(WR_SEL_B, 0, 64'd2);
      wr(WR_SEL_B, 1, 64'd3);
      run(2, 1'b0, 11, "t2");
      rd(0, d); chk("t2 R0", d, 64'd2);
      rd(1, d); chk("t2 R1", d, 64'd5);
      rd(2, d); chk("t2 R2", d, 64'd3);
      rd(3, d); chk("t2 R3", d, 64'd0);
      rd(4, d); chk("t2 R4", d, exp_r[4]);

      // square mode ignores B
      wr(WR_SEL_A, 0, 64'd3);
      wr(WR_SEL_A, 1, 64'd0);
      wr(WR_SEL_B, 0, ONES);
      wr(WR_SEL_B, 1, ONES);
      run(2, 1'b1, 11, "t4");
      rd(0, d); chk("t4 R0", d, 64'd9);
      rd(1, d); chk("t4 R1", d, 64'd0);
      rd(2, d); chk("t4 R2", d, 64'd0);
      rd(3, d); chk("t4 R3", d, 64'd0);

      // length errors
      start_job(0, 1'b0);
      chk("len0 err", W'(bus.err), 1);
      chk("len0 busy", W'(bus.busy), 0);
      @(posedge clk);
      #1 chk("len0 err pulse", W'(bus.err), 0);
      start_job(65, 1'b0);
      chk("len65 err", W'(bus.err), 1);
      chk("len65 busy", W'(bus.busy), 0);

      // write and start while busy are ignored
      start_job(2, 1'b1);
      n = 0;
      while (!bus.done && n < 100) begin
         if (n == 2) begin
            bus.wr_en   = 1'b1;
            bus.wr_sel  = WR_SEL_A;
            bus.wr_addr = '0;
            bus.wr_data = 64'd5;
            bus.start   = 1'b1;
            bus.len     = 7'd1;
         end else if (n == 3) begin
            bus.wr_en = 1'b0;
            bus.start = 1'b0;
         end
         @(posedge clk);
         #1 n++;
      end
      if (!bus.done) n = -1;
      chk("t5 cycles", W'(n), 11);
      rd(0, d); chk("t5 R0", d, 64'd9);
      rd(1, d); chk("t5 R1", d, 64'd0);
      run(1, 1'b1, 5, "t5b");
      rd(0, d); chk("t5b R0", d, 64'd9);
      rd(1, d); chk("t5b R1", d, 64'd0);

      // reset in the middle of MAC
      start_job(64, 1'b0);
      repeat (300) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      chk("t6 busy", W'(bus.busy), 0);
      chk("t6 done", W'(bus.done), 0);
      rst = 1'b0;
      seen = 0;
      repeat (50) begin
         @(posedge clk);
         #1 if (bus.done || bus.busy) seen = 1;
      end
      chk("t6 quiet", W'(seen), 0);

      // rerun; B written in the start cycle
      wr(WR_SEL_A, 0, ONES);
      @(negedge clk);
      bus.wr_en   = 1'b1;
      bus.wr_sel  = WR_SEL_B;
      bus.wr_addr = '0;
      bus.wr_data = ONES;
      bus.start   = 1'b1;
      bus.len     = 7'd1;
      bus.sq      = 1'b0;
      @(posedge clk);
      #1;
      bus.wr_en = 1'b0;
      bus.start = 1'b0;
      wait_done(100, n);
      chk("t6b cycles", W'(n), 5);
      rd(0, d);
      chk("t6b R0", d, 64'h1);
      rd(1, d);
      chk("t6b R1", d, 64'hFFFF_FFFF_FFFF_FFFE);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bigmul_unit_param.md
Name: bigmul_unit_param

Overview:
- Parametrised successor to the fixed 64×64-bit-limb CSA multiplier.
- Schoolbook multi-precision multiplier: operand A and operand B are held in internal limb stores, each MAX_LIMBS × LIMB_W. The 2·len-limb product goes to a result store.
- Adds over the fixed unit: a real load/read port interface, runtime operand length, a squaring mode and length error reporting.
- Sits beside the core as a memory-mapped accelerator. The core loads operands, pulses start, waits for done, then reads the result.

Parameters:
- LIMB_W, 64, limb width in bits (≥8).
- MAX_LIMBS, 64, maximum limbs per operand (≥1).
- LEN_W, $clog2(MAX_LIMBS+1), width of the len input.
- AW, $clog2(MAX_LIMBS), operand address width.
- RAW, $clog2(2*MAX_LIMBS), result address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a multiply; sampled only in IDLE.
- len  in  LEN_W  operand length in limbs; sampled with start.
- sq  in  1  square mode (B := A); sampled with start.
- wr_en  in  1  operand write strobe.
- wr_sel  in  1  0=A store, 1=B store.
- wr_addr  in  AW  limb index.
- wr_data  in  LIMB_W  limb value, little-endian limb order.
- rd_addr  in  RAW  result limb index.
- rd_data  out  LIMB_W  registered result limb, 1-cycle latency.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse on completion.
- err  out  1  one-cycle pulse on a rejected start.

Behaviour:
- Reset: busy=0, done=0, err=0, rd_data=0, FSM=IDLE, all counters 0. Store contents are not cleared by reset.
- FSM states: IDLE → CLEAR → MAC → FIN → IDLE.
- IDLE:
  - start=1 with 1≤len≤MAX_LIMBS: latch len and sq, go to CLEAR, busy=1 next cycle.
  - start=1 with len=0 or len>MAX_LIMBS: err=1 next cycle only, stay IDLE, stores untouched.
- CLEAR: writes R[k]=0 for k=0..2·len−1, one limb per cycle, 2·len cycles.
- MAC: outer index i=0..len−1. Each row takes len+1 cycles:
  - Step j<len: t = R[i+j] + A[i]·Bsel[j] + carry, where Bsel is A if sq else B. Write R[i+j]=t[LIMB_W-1:0], carry=t[2·LIMB_W-1:LIMB_W].
  - Step j=len: R[i+len]=carry, carry=0.
  - t is 2·LIMB_W bits and never overflows: max is (2^W−1)²+2(2^W−1) = 2^(2W)−1.
  - Row count is len·(len+1) cycles.
- FIN: done=1 and busy=0 in the same cycle, then IDLE.
- Latency: the start-accepting edge to the done-high cycle is 2·len + len·(len+1) + 1 cycles (len=64 → 4289).
- wr_en while busy: ignored, no store change. wr_en in IDLE: one-cycle write.
- start while busy: ignored.
- rd_data = R[rd_addr] registered every cycle, including while busy (partial contents). rd_addr ≥ 2·MAX_LIMBS returns 0.
- Limbs of R at index ≥ 2·len are not modified by a run.
- rst mid-operation: abort next edge to IDLE, busy=0, no done pulse. The R contents are then unspecified; A and B are retained.
- wr_en and start in the same IDLE cycle: the write lands, and the run uses the new value.

Decomposition:
- Package bigmul_pkg holds:
  - the state enum (IDLE/CLEAR/MAC/FIN);
  - the width helper functions;
  - the WR_SEL_A/WR_SEL_B constants.
- Sub-module limb_mac: combinational LIMB_W×LIMB_W multiply plus two LIMB_W addends, producing a 2·LIMB_W result. It is the natural swap point for a later CSA/pipelined version.

Test Plan:
1. Single max limb: len=1, A[0]=B[0]=FFFFFFFFFFFFFFFF → R[0]=0000000000000001, R[1]=FFFFFFFFFFFFFFFE, done 5 cycles after start edge.
2. Two limbs: A={A0=1,A1=1}, B={B0=2,B1=3}, len=2 → R[0..3]=2,5,3,0; done after 11 cycles; R[4] unchanged from its pre-run value.
3. Full size: len=64, all A/B limbs 7FFFFFFFFFFFFFFF → done after 4289 cycles; R[0]=0000000000000001; all 128 limbs match a software bignum model.
4. Square mode: sq=1, len=2, A={3,0}, B filled with FFFF... → R[0..3]=9,0,0,0 (B ignored).
5. Errors and ignores:
   - len=0 → err pulse, busy stays 0.
   - len=65 → err pulse.
   - wr_en during busy → store unchanged on readback.
   - second start during busy → no effect on cycle count.
6. Reset mid-run: rst asserted during MAC of a len=64 job → busy=0 next cycle, no done pulse; then len=1 run as in case 1 → correct result.
